// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared types and board defaults for the input conditioner
package board_io_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } debounce_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int BOARD_N_SWITCHES        = 10;
    localparam int BOARD_N_BUTTONS         = 4;

endpackage

// File: rtl/board_input_conditioner_if.sv
// rtl/board_input_conditioner_if.sv - raw pin inputs and conditioned outputs of the board conditioner
interface board_input_conditioner_if #(
    parameter int N_SWITCHES = 10,
    parameter int N_BUTTONS  = 4
);
    logic [N_SWITCHES-1:0] switches_raw;
    logic [N_BUTTONS-1:0]  push_buttons_raw;
    logic [N_SWITCHES-1:0] switches;
    logic [N_BUTTONS-1:0]  push_buttons;
    logic [N_BUTTONS-1:0]  button_press;
    logic [N_BUTTONS-1:0]  button_release;

    modport master (
        output switches_raw, push_buttons_raw,
        input  switches, push_buttons, button_press, button_release
    );

    modport slave (
        input  switches_raw, push_buttons_raw,
        output switches, push_buttons, button_press, button_release
    );
endinterface

// File: rtl/board_input_conditioner_debounce_cell.sv
// rtl/board_input_conditioner_debounce_cell.sv - one channel: synchroniser, debounce FSM, optional edge flops (BOARD_INPUT_EDGE_EN)
module debounce_cell
    import board_io_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic async_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic                   w_in;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    debounce_state_t        r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic                   r_level, w_level_nxt;
    logic                   w_accept;

    // Inverting before the first flop lets reset-to-0 mean "inactive" for every channel
    assign w_in   = INVERT ? ~i_raw : i_raw;
    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_sync  <= '0;
            r_state <= STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], w_in};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            STABLE: begin
                if (w_sync != r_level) begin
                    w_state_nxt = SETTLING;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            SETTLING: begin
                if (w_sync == r_level || r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_accept    = (r_state == SETTLING) && (w_sync != r_level) && (r_cnt == CNT_LAST);
        w_level_nxt = w_accept ? w_sync : r_level;
    end

    assign o_level = r_level;

`ifdef BOARD_INPUT_EDGE_EN
    logic r_press, r_release;

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_accept & w_sync;
            r_release <= w_accept & ~w_sync;
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;
`else
    assign o_press   = 1'b0;
    assign o_release = 1'b0;
`endif

endmodule

// File: rtl/board_input_conditioner.sv
// rtl/board_input_conditioner.sv - top: one debounce_cell per switch and button; edge pulses need BOARD_INPUT_EDGE_EN
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int N_SWITCHES      = BOARD_N_SWITCHES,
    parameter int N_BUTTONS       = BOARD_N_BUTTONS,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                      clk,
    input  logic                      async_rst,
    board_input_conditioner_if.slave  bus
);
    logic [N_SWITCHES-1:0] w_sw_level;
    logic [N_BUTTONS-1:0]  w_btn_level;
    logic [N_BUTTONS-1:0]  w_btn_press;
    logic [N_BUTTONS-1:0]  w_btn_release;

    for (genvar gi = 0; gi < N_SWITCHES; gi++) begin : g_sw
        logic w_press_unused, w_release_unused;

        debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (1'b0)
        ) u_cell (
            .clk       (clk),
            .async_rst (async_rst),
            .i_raw     (bus.switches_raw[gi]),
            .o_level   (w_sw_level[gi]),
            .o_press   (w_press_unused),
            .o_release (w_release_unused)
        );
    end

    // Buttons are active-low on the board
    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
        debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (1'b1)
        ) u_cell (
            .clk       (clk),
            .async_rst (async_rst),
            .i_raw     (bus.push_buttons_raw[gi]),
            .o_level   (w_btn_level[gi]),
            .o_press   (w_btn_press[gi]),
            .o_release (w_btn_release[gi])
        );
    end

    assign bus.switches       = w_sw_level;
    assign bus.push_buttons   = w_btn_level;
    assign bus.button_press   = w_btn_press;
    assign bus.button_release = w_btn_release;

endmodule

// File: doc/board_input_conditioner.md
# board_input_conditioner

Conditions the raw Cyclone V board inputs (slide switches and push buttons) before they reach `toplevel`. It synchronises each pin into the `clk` domain, debounces it, and inverts the active-low push buttons to active-high. It also optionally produces one-cycle press/release pulses. Its clean `switches`/`push_buttons` outputs drive the matching `toplevel` inputs directly.

## Interface
Parameters:
- `N_SWITCHES`, 10, number of slide switches
- `N_BUTTONS`, 4, number of push buttons
- `SYNC_STAGES`, 2, flip-flop synchroniser depth; legal range ≥2
- `DEBOUNCE_CYCLES`, 50000, consecutive identical samples required to accept a change (1 ms at 50 MHz); legal range ≥2

Ports:
- `clk`  in  1  system clock
- `async_rst`  in  1  asynchronous, active-low reset
- `switches_raw`  in  N_SWITCHES  raw switch pins, active-high, asynchronous to `clk`
- `push_buttons_raw`  in  N_BUTTONS  raw button pins, active-low (pressed = 0), asynchronous
- `switches`  out  N_SWITCHES  debounced switch levels, active-high
- `push_buttons`  out  N_BUTTONS  debounced button levels, active-high (pressed = 1)
- `button_press`  out  N_BUTTONS  one-cycle pulse on each debounced 0→1 transition
- `button_release`  out  N_BUTTONS  one-cycle pulse on each debounced 1→0 transition

## Operation
- Each input bit is handled by an independent channel.
- Channel pipeline: synchroniser → debounce FSM → level/edge registers.
- Button channels invert the signal at the synchroniser input. All later logic is active-high.
- Debounce FSM per channel, with counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`:
  - **STABLE**:
    - If `sync == level`: `cnt` holds 0.
    - If `sync != level`: go to SETTLING with `cnt` = 1.
  - **SETTLING**:
    - If `sync == level` (glitch): return to STABLE, `cnt` = 0.
    - Else if `cnt == DEBOUNCE_CYCLES-1`: set `level <= sync`, return to STABLE, `cnt` = 0.
    - Else: `cnt` increments.
- `cnt` never wraps. It is cleared on acceptance or on a glitch.
- Edge pulses are registered together with the `level` update:
  - `button_press[i]` is 1 in exactly the first cycle in which `push_buttons[i]` reads 1.
  - `button_release[i]` is 1 in exactly the first cycle in which `push_buttons[i]` reads 0.
- Switches have no edge outputs.
- Simultaneous changes on multiple channels are independent. No arbitration occurs.
- Reset, including a reset asserted mid-settle:
  - All synchroniser flops clear to the inactive value: switch flops to 0; button flops to 0 after inversion, i.e. raw 1.
  - FSM goes to STABLE, `cnt` = 0.
  - All outputs go to 0.
  - Any pending settle is discarded.
- After reset release, an input already held active is accepted SYNC_STAGES+DEBOUNCE_CYCLES cycles later, as a normal transition, and produces a press pulse.

## Timing
- Latency from a raw pin change to the synchroniser output: SYNC_STAGES rising edges. Metastability-tolerant, no exact value guaranteed.
- Latency from the synchroniser output change to the `level` update: DEBOUNCE_CYCLES rising edges, provided the value is held throughout.
- Total latency for a clean raw change: SYNC_STAGES + DEBOUNCE_CYCLES cycles. The edge pulse appears in that same cycle.
- Pulses last exactly one cycle.
- Minimum spacing between successive accepted transitions on one channel: DEBOUNCE_CYCLES cycles.
- A raw glitch shorter than DEBOUNCE_CYCLES synchronised samples never reaches the outputs.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- Macro `BOARD_INPUT_EDGE_EN`:
  - **Defined**: press/release edge registers are built as described above.
  - **Undefined**: `button_press` and `button_release` are tied to constant 0, and no edge flops are generated. Level outputs are unaffected.

## Structure
- Shared package `board_io_pkg`:
  - `debounce_state_t` enum (STABLE, SETTLING)
  - default `DEBOUNCE_CYCLES` and `SYNC_STAGES` localparams
  - board widths `N_SWITCHES` = 10 and `N_BUTTONS` = 4
- Sub-module `debounce_cell`:
  - one channel: synchroniser + FSM + counter + optional edge flops
  - parameters SYNC_STAGES, DEBOUNCE_CYCLES, INVERT
  - the top generates N_SWITCHES + N_BUTTONS instances

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
- **Clean press**: `push_buttons_raw[0]` 1→0 and held → `push_buttons[0]`=1 exactly 6 cycles later. `button_press[0]`=1 for that single cycle, `button_release`=0.
- **Bounce rejection**: raw button toggles 0/1 every 2 cycles for 20 cycles, then holds 0 → no output change during bouncing. Level goes to 1 six cycles after the final hold begins, with a single press pulse.
- **Switch change with simultaneous channels**: `switches_raw` 0x000→0x201 together with `push_buttons_raw[3]` 1→0 → `switches`=0x201 and `push_buttons[3]`=1 in the same cycle, 6 cycles later.
- **Release**: held button is released → `push_buttons`=0 after 6 cycles, with one `button_release` pulse.
- **Reset mid-settle**: `async_rst` pulsed low 3 cycles into a settle → all outputs 0 immediately and no pulse. After release, with the input still active, the level asserts 6 cycles later with a press pulse.
- **Macro off**: rebuild without `BOARD_INPUT_EDGE_EN` and rerun the clean-press scenario → levels identical, `button_press`/`button_release` constantly 0.
